hamming_rx_buffer: RTL

- Receive-side stage on one router output channel; consumes the 7-bit Hamming(7,4) codeword the router emits for that channel.
- Registers each codeword and corrects any single-bit error by syndrome.
- Buffers the recovered 4-bit nibbles in a small FIFO and hands them downstream over a valid/ready handshake.
- One instance per router output channel.

---
 rtl/hamming_rx_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hamming_rx_buffer.sv
// hamming_rx_buffer: receive stage for one router output channel.
// Registers a Hamming(7,4) codeword, corrects any single-bit error, and
// queues the recovered nibble in a DEPTH-entry FIFO drained over valid/ready.
// Optional macro HAMM_RX_STATS_EN builds the corrected-error counter
// (err_cnt) and the last-syndrome register (last_syn). Without it both
// outputs are tied to zero, and the data path and latency are unchanged.
module hamming_rx_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       last_syn
);

  localparam int AW = $clog2(DEPTH);

  logic             s1_valid;
  logic [6:0]       s1_code;
  logic             rdy_en;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fifo_count;
  logic [3:0]       mem [DEPTH];
  logic [2:0]       syn;
  logic [6:0]       fixed;
  logic [3:0]       nibble;
  logic [AW+1:0]    occupancy;
  logic             push;
  logic             pop;

  assign push = s1_valid;
  assign pop  = out_valid && out_ready;

  // Occupancy counts the codeword still in stage 1. Because of that, a
  // stage-2 write can never land on a full FIFO.
  assign occupancy = {1'b0, fifo_count} + (AW+2)'(s1_valid);
  assign in_ready  = rdy_en && (occupancy < (AW+2)'(DEPTH));

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 4'd0;

  // Syndrome of the staged codeword, single-bit correction, nibble extract
  always_comb begin
    syn[0] = s1_code[0] ^ s1_code[2] ^ s1_code[4] ^ s1_code[6];
    syn[1] = s1_code[1] ^ s1_code[2] ^ s1_code[5] ^ s1_code[6];
    syn[2] = s1_code[3] ^ s1_code[4] ^ s1_code[5] ^ s1_code[6];
    fixed  = s1_code;
    if (syn != 3'd0) begin
      fixed[syn - 3'd1] = ~s1_code[syn - 3'd1];
    end
    nibble = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

  // Stage 1 capture register; never stalls, so it simply follows the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= 7'd0;
    end else begin
      s1_valid <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_code <= in_code;
      end
    end
  end

  // Hold in_ready low until the first edge after reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since out_data is masked when empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= nibble;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef HAMM_RX_STATS_EN
  // Saturating corrected-error counter and last syndrome, per stage-2 write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      last_syn <= 3'd0;
    end else if (push) begin
      last_syn <= syn;
      if ((syn != 3'd0) && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign err_cnt  = '0;
  assign last_syn = 3'd0;
`endif

endmodule
